// File: rtl/division_ip_core_pkg.sv
// division_ip_core_pkg: default widths and pipeline depth helper for the divider
package division_ip_core_pkg;
  localparam int DEF_DIVIDEND_W = 32;
  localparam int DEF_DIVISOR_W = 32;
  localparam int DEF_FRAC_W = 8;
  function automatic int pipe_latency(input int q_w);
    return q_w + 2;
  endfunction
endpackage

// File: rtl/division_ip_core_div_stage.sv
// div_stage: one restoring divide step producing a single quotient bit
module div_stage
  import division_ip_core_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W,
  parameter int Q_W = DEF_DIVIDEND_W + DEF_FRAC_W
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 src_valid,
  input  logic                 src_neg,
  input  logic                 src_zero,
  input  logic [DIVISOR_W-1:0] src_rem,
  input  logic [DIVISOR_W-1:0] src_dmag,
  input  logic [Q_W-1:0]       src_nq,
  output logic                 dst_valid,
  output logic                 dst_neg,
  output logic                 dst_zero,
  output logic [DIVISOR_W-1:0] dst_rem,
  output logic [DIVISOR_W-1:0] dst_dmag,
  output logic [Q_W-1:0]       dst_nq
);
  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] diff;
  logic               ge;
  // shift the next numerator bit into the remainder and trial-subtract; remainder < divisor keeps diff's msb a clean borrow
  always_comb begin
    trial = {src_rem, src_nq[Q_W-1]};
    diff = trial - {1'b0, src_dmag};
    ge = ~diff[DIVISOR_W];
  end
  // register restored remainder; nq shifts numerator bits out the top and quotient bits in the bottom
  always_ff @(posedge aclk) begin
    dst_valid <= aresetn & src_valid;
    dst_neg <= src_neg;
    dst_zero <= src_zero;
    dst_dmag <= src_dmag;
    dst_rem <= ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    dst_nq <= {src_nq[Q_W-2:0], ge};
  end
endmodule

// File: rtl/division_ip_core.sv
// division_ip_core: fully pipelined signed fixed-point divider, one pair per clock
module division_ip_core
  import division_ip_core_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W = DEF_DIVISOR_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_axis_dividend_tvalid,
  input  logic [DIVIDEND_W-1:0]        s_axis_dividend_tdata,
  input  logic                         s_axis_divisor_tvalid,
  input  logic [DIVISOR_W-1:0]         s_axis_divisor_tdata,
  output logic                         m_axis_dout_tvalid,
  output logic [DIVIDEND_W+FRAC_W-1:0] m_axis_dout_tdata,
  output logic                         m_axis_dout_tuser
);
  localparam int Q_W = DIVIDEND_W + FRAC_W;
  localparam int LATENCY = pipe_latency(Q_W);
  localparam int STAGES = LATENCY - 2;
  logic                  accept;
  logic [DIVIDEND_W-1:0] dividend_mag;
  logic [DIVISOR_W-1:0]  divisor_mag;
  logic                  s0_valid;
  logic                  s0_neg;
  logic                  s0_zero;
  logic [Q_W-1:0]        s0_nq;
  logic [DIVISOR_W-1:0]  s0_dmag;
  logic                  st_valid [STAGES];
  logic                  st_neg [STAGES];
  logic                  st_zero [STAGES];
  logic [DIVISOR_W-1:0]  st_rem [STAGES];
  logic [DIVISOR_W-1:0]  st_dmag [STAGES];
  logic [Q_W-1:0]        st_nq [STAGES];
  logic [Q_W-1:0]        quot;
  // operand magnitudes; the most negative dividend maps to its unsigned magnitude
  always_comb begin
    accept = s_axis_dividend_tvalid & s_axis_divisor_tvalid;
    dividend_mag = s_axis_dividend_tdata[DIVIDEND_W-1] ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    divisor_mag = s_axis_divisor_tdata[DIVISOR_W-1] ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
    quot = st_nq[STAGES-1];
  end
  // input register: scaled numerator, divisor magnitude, result sign and zero flag
  always_ff @(posedge aclk) begin
    s0_valid <= aresetn & accept;
    s0_nq <= {dividend_mag, {FRAC_W{1'b0}}};
    s0_dmag <= divisor_mag;
    s0_neg <= s_axis_dividend_tdata[DIVIDEND_W-1] ^ s_axis_divisor_tdata[DIVISOR_W-1];
    s0_zero <= ~|s_axis_divisor_tdata;
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      div_stage #(.DIVISOR_W(DIVISOR_W), .Q_W(Q_W)) u_stage (
        .aclk(aclk), .aresetn(aresetn),
        .src_valid(s0_valid), .src_neg(s0_neg), .src_zero(s0_zero),
        .src_rem({DIVISOR_W{1'b0}}), .src_dmag(s0_dmag), .src_nq(s0_nq),
        .dst_valid(st_valid[i]), .dst_neg(st_neg[i]), .dst_zero(st_zero[i]),
        .dst_rem(st_rem[i]), .dst_dmag(st_dmag[i]), .dst_nq(st_nq[i])
      );
    end else begin : g_next
      div_stage #(.DIVISOR_W(DIVISOR_W), .Q_W(Q_W)) u_stage (
        .aclk(aclk), .aresetn(aresetn),
        .src_valid(st_valid[i-1]), .src_neg(st_neg[i-1]), .src_zero(st_zero[i-1]),
        .src_rem(st_rem[i-1]), .src_dmag(st_dmag[i-1]), .src_nq(st_nq[i-1]),
        .dst_valid(st_valid[i]), .dst_neg(st_neg[i]), .dst_zero(st_zero[i]),
        .dst_rem(st_rem[i]), .dst_dmag(st_dmag[i]), .dst_nq(st_nq[i])
      );
    end
  end
  // output register: apply sign, force zero data on divide-by-zero and when idle
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata <= '0;
      m_axis_dout_tuser <= 1'b0;
    end else begin
      m_axis_dout_tvalid <= st_valid[STAGES-1];
      m_axis_dout_tuser <= st_valid[STAGES-1] & st_zero[STAGES-1];
      m_axis_dout_tdata <= (st_valid[STAGES-1] && !st_zero[STAGES-1]) ? (st_neg[STAGES-1] ? -quot : quot) : '0;
    end
  end
endmodule

// File: tb/tb_division_ip_core.sv
// tb_division_ip_core: directed and model-checked stimulus for the pipelined divider
module tb_division_ip_core;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        dvd_v;
  logic [31:0] dvd;
  logic        dvs_v;
  logic [31:0] dvs;
  logic        out_v;
  logic [39:0] out_d;
  logic        out_u;
  int          compared = 0;
  int          mismatched = 0;
  int          pulses;
  int          pulse_at;
  logic [39:0] got;
  logic [41:0] exp_q [50];
  logic [31:0] ra;
  logic [31:0] rb;

  division_ip_core dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_dividend_tvalid(dvd_v),
    .s_axis_dividend_tdata(dvd),
    .s_axis_divisor_tvalid(dvs_v),
    .s_axis_divisor_tdata(dvs),
    .m_axis_dout_tvalid(out_v),
    .m_axis_dout_tdata(out_d),
    .m_axis_dout_tuser(out_u)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] model(input logic [31:0] a, input logic [31:0] b);
    longint n;
    longint q;
    if (b == 32'd0) return {1'b1, 1'b1, 40'h0};
    n = longint'($signed(a)) * 256;
    q = n / longint'($signed(b));
    return {1'b1, 1'b0, q[39:0]};
  endfunction

  task automatic drive(input logic va, input logic [31:0] a, input logic vb, input logic [31:0] b);
    dvd_v = va;
    dvd = a;
    dvs_v = vb;
    dvs = b;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [39:0] exp_d, input logic exp_u);
    drive(1'b1, a, 1'b1, b);
    @(negedge aclk);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (40) @(negedge aclk);
    chk({tag, "_early"}, {out_v, out_u, out_d}, 42'h0);
    @(negedge aclk);
    chk(tag, {out_v, out_u, out_d}, {1'b1, exp_u, exp_d});
    @(negedge aclk);
    chk({tag, "_after"}, {out_v, out_u, out_d}, 42'h0);
  endtask

  initial begin
    aresetn = 1'b0;
    drive(1'b1, 32'd9, 1'b1, 32'd3);
    repeat (3) @(negedge aclk);
    chk("reset_state", {out_v, out_u, out_d}, 42'h0);
    aresetn = 1'b1;
    run_one("p100_d7", 32'd100, 32'd7, 40'h00_0000_0E49, 1'b0);
    run_one("m100_d7", -32'sd100, 32'd7, 40'hFF_FFFF_F1B7, 1'b0);
    run_one("p1_m3", 32'd1, -32'sd3, 40'hFF_FFFF_FFAB, 1'b0);
    run_one("p5_d0", 32'd5, 32'd0, 40'h0, 1'b1);
    run_one("p0_d5", 32'd0, 32'd5, 40'h0, 1'b0);
    run_one("max_d1", 32'h7FFF_FFFF, 32'd1, 40'h7F_FFFF_FF00, 1'b0);
    run_one("p7_m100", 32'd7, -32'sd100, 40'hFF_FFFF_FFEF, 1'b0);
    run_one("m1_d1", 32'hFFFF_FFFF, 32'd1, 40'hFF_FFFF_FF00, 1'b0);
    for (int c = 0; c < 95; c++) begin
      if (c >= 42 && c < 92) chk("burst", {out_v, out_u, out_d}, exp_q[c-42]);
      else chk("burst_idle", {out_v, out_u, out_d}, 42'h0);
      if (c < 50) begin
        ra = $urandom;
        rb = (c % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
        if (c % 5 == 1) rb = -rb;
        if (c == 7) rb = 32'd0;
        exp_q[c] = model(ra, rb);
        drive(1'b1, ra, 1'b1, rb);
      end else drive(1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge aclk);
    end
    pulses = 0;
    pulse_at = -1;
    got = 40'h0;
    for (int c = 0; c < 60; c++) begin
      if (c < 3) drive(1'b1, 32'd999, 1'b0, 32'd3);
      else if (c == 3) drive(1'b1, 32'd64, 1'b1, 32'd2);
      else drive(1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge aclk);
      if (out_v) begin
        pulses++;
        pulse_at = c;
        got = out_d;
      end
    end
    chk("lone_count", 42'(pulses), 42'd1);
    chk("lone_data", {2'b00, got}, {2'b00, 40'h00_0000_2000});
    chk("lone_latency", 42'(pulse_at), 42'd44);
    for (int c = 0; c < 20; c++) begin
      if (c < 10) drive(1'b1, 32'(c * 3 + 1), 1'b1, 32'd5);
      else if (c == 19) begin
        aresetn = 1'b0;
        drive(1'b1, 32'd12, 1'b1, 32'd4);
      end else drive(1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge aclk);
    end
    chk("rst_clear", {out_v, out_u, out_d}, 42'h0);
    aresetn = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge aclk);
      if (out_v) pulses++;
    end
    chk("rst_discard", 42'(pulses), 42'd0);
    run_one("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 40'h80_0000_0000, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
